// File: rtl/lsu_pkg.sv
// Shared types, funct3 size codes and byte-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B, SZ_BU: be = 4'b0001 << lane;
      SZ_H, SZ_HU: be = 4'b0011 << {lane[1], 1'b0};
      SZ_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Unsigned sizes only make sense for loads; everything else must be naturally aligned.
  function automatic logic access_ok(input logic [2:0] size, input logic [1:0] lane,
                                     input logic we);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !we;
      SZ_H:    ok = !lane[0];
      SZ_HU:   ok = !we && !lane[0];
      SZ_W:    ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit (master) and data memory (slave).
// Handshake: master raises req with we/addr/be/wdata stable and holds them until the slave
// returns ack for exactly one cycle; rdata is valid only in that ack cycle.
interface lsu_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_extend.sv
// Load-data formatter: selects the addressed lane of the bus word and sign/zero-extends it.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    ext = {{24{b[7]}}, b};
      SZ_BU:   ext = {24'd0, b};
      SZ_H:    ext = {{16{h[15]}}, h};
      SZ_HU:   ext = {16'd0, h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one valid/ack bus transaction per instruction, stalling the core via mem_wait.
// Optional REQ-phase watchdog with abort pulse is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [2:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic              mem_wait,
  output logic [31:0]       ld_data,
  output logic              misalign,
`ifdef LSU_TIMEOUT_EN
  output logic              timeout,
`endif
  output state_t            dbg_state,
  lsu_bus_if.master         bus
);

  state_t      state, next_state;
  logic        req, legal, expire;
  logic [1:0]  a_lane;
  logic [2:0]  a_size;
  logic [31:0] ext_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] cnt;
  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Store wins when both strobes are up, so st_req alone decides the direction.
  assign req       = ld_req | st_req;
  assign legal     = access_ok(size, addr[1:0], st_req);
  assign mem_wait  = ((state == IDLE) && req) || (state == REQ);
  assign bus.req   = (state == REQ);
  assign dbg_state = state;

  lsu_extend u_extend (
    .rdata (bus.rdata),
    .lane  (a_lane),
    .size  (a_size),
    .ext   (ext_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = legal ? REQ : DONE;
      REQ:     if (bus.ack || expire) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= 4'b0000;
      bus.wdata <= 32'd0;
      a_lane    <= 2'b00;
      a_size    <= 3'b000;
      ld_data   <= 32'd0;
      misalign  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      timeout   <= 1'b0;
      cnt       <= '0;
`endif
    end else begin
      misalign <= 1'b0;
      if ((state == IDLE) && req) begin
        if (legal) begin
          bus.we    <= st_req;
          bus.addr  <= {addr[ADDR_W-1:2], 2'b00};
          bus.be    <= be_gen(size, addr[1:0]);
          bus.wdata <= wdata_gen(size, st_data);
          a_lane    <= addr[1:0];
          a_size    <= size;
        end else begin
          misalign <= 1'b1;
          ld_data  <= 32'd0;
        end
      end
      if ((state == REQ) && bus.ack && !bus.we) ld_data <= ext_data;
`ifdef LSU_TIMEOUT_EN
      // An ack in the final watchdog cycle still completes the access normally.
      timeout <= 1'b0;
      if (state != REQ) begin
        cnt <= '0;
      end else if (!bus.ack) begin
        if (expire) begin
          timeout <= 1'b1;
          ld_data <= TIMEOUT_DATA;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit; timeout scenarios compile in with LSU_TIMEOUT_EN.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int GUARD  = 500;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              ld_req, st_req, mem_wait, misalign;
  logic [2:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       st_data, ld_data;
  state_t            dbg_state;
`ifdef LSU_TIMEOUT_EN
  logic              timeout;
`endif

  lsu_bus_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(
    .ADDR_W(ADDR_W)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ld_req    (ld_req),
    .st_req    (st_req),
    .size      (size),
    .addr      (addr),
    .st_data   (st_data),
    .mem_wait  (mem_wait),
    .ld_data   (ld_data),
    .misalign  (misalign),
`ifdef LSU_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_done_q[$];   // {timeout, misalign, ld_data}
  logic [68:0] exp_bus_q[$];    // {we, addr, be, wdata}
  logic [31:0] model_ld = 32'd0;

  int          ack_delay = 0;
  logic [31:0] ack_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_legal(input bit we, input logic [2:0] sz, input logic [31:0] a);
    int nb;
    if (sz == 3'd3 || sz[2:1] == 2'b11) return 1'b0;
    if (we && sz[2]) return 1'b0;
    nb = 1 << sz[1:0];
    return (a % nb) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
    int nb, mask;
    nb   = 1 << sz[1:0];
    mask = ((1 << nb) - 1) << (a % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] w;
    int nb;
    nb = 1 << sz[1:0];
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a,
                                             input logic [31:0] w);
    int nb;
    longint v;
    nb = 1 << sz[1:0];
    if (nb == 4) return w;
    v = longint'((w >> (8 * (a % 4))) % (32'd1 << (8 * nb)));
    if (!sz[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // ---------------- bus responder ----------------
  initial begin
    int req_cycles;
    req_cycles = 0;
    bus.ack    = 1'b0;
    bus.rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.req && !bus.ack) begin
        if (req_cycles == ack_delay) begin
          bus.ack   = 1'b1;
          bus.rdata = ack_rdata;
        end else begin
          bus.rdata = $urandom;
        end
        req_cycles++;
      end else begin
        bus.ack    = 1'b0;
        req_cycles = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    logic [68:0] cur;
    bit in_txn, bogus;
    in_txn = 0;
    bogus  = 0;
    cur    = '0;
    forever begin
      @(negedge clk);
      if (reset_n && bus.req) begin
        if (!in_txn) begin
          in_txn = 1;
          bogus  = (exp_bus_q.size() == 0);
          if (bogus) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_bus_req: got req=1 addr=%h expected no bus cycle", bus.addr);
          end else begin
            cur = exp_bus_q.pop_front();
          end
        end
        if (!bogus) begin
          check("bus_we", 32'(bus.we), 32'(cur[68]));
          check("bus_addr", bus.addr, cur[67:36]);
          check("bus_be", 32'(bus.be), 32'(cur[35:32]));
          if (cur[68]) check("bus_wdata", bus.wdata, cur[31:0]);
        end
      end else begin
        in_txn = 0;
      end
    end
  end

  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (dbg_state == DONE) begin
          if (exp_done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got DONE expected no completion");
          end else begin
            e = exp_done_q.pop_front();
            check("done_misalign", 32'(misalign), 32'(e[32]));
            check("done_ld_data", ld_data, e[31:0]);
            check("done_mem_wait", 32'(mem_wait), 32'd0);
`ifdef LSU_TIMEOUT_EN
            check("done_timeout", 32'(timeout), 32'(e[33]));
`endif
          end
        end else begin
          check("misalign_outside_done", 32'(misalign), 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_op(input bit ld, input bit st, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int delay);
    bit we, ok, tmo;
    int exp_wait, waited, guard;
    logic [31:0] exp_ld;
    we  = st;
    ok  = model_legal(we, sz, a);
    tmo = 0;
    if (!ok) begin
      exp_ld   = 32'd0;
      exp_wait = 1;
    end else begin
      exp_wait = 2 + delay;
`ifdef LSU_TIMEOUT_EN
      if (delay >= TMO) begin
        tmo      = 1;
        exp_wait = 1 + TMO;
      end
`endif
      if (tmo)      exp_ld = 32'hDEAD_BEEF;
      else if (!we) exp_ld = model_load(sz, a, rd);
      else          exp_ld = model_ld;
      exp_bus_q.push_back({we, a & ~32'd3, model_be(sz, a), model_wdata(sz, d)});
    end
    model_ld = exp_ld;
    exp_done_q.push_back({tmo, !ok, exp_ld});

    ld_req    = ld;
    st_req    = st;
    size      = sz;
    addr      = a;
    st_data   = d;
    ack_delay = delay;
    ack_rdata = rd;
    waited    = 0;
    guard     = 0;
    do begin
      @(negedge clk);
      if (mem_wait) waited++;
      guard++;
    end while (dbg_state != DONE && guard < GUARD);
    if (guard >= GUARD) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: got no DONE expected DONE within %0d cycles", GUARD);
      finish_report();
    end
    check("mem_wait_cycles", waited, exp_wait);
    #1;
    ld_req = 1'b0;
    st_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ld_req  = 1'b0;
    st_req  = 1'b0;
    size    = 3'b000;
    addr    = '0;
    st_data = 32'd0;

    #12;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mem_wait", 32'(mem_wait), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_bus_req", 32'(bus.req), 32'd0);
    check("rst_bus_we", 32'(bus.we), 32'd0);
    check("rst_bus_addr", bus.addr, 32'd0);
    check("rst_bus_be", 32'(bus.be), 32'd0);
    check("rst_bus_wdata", bus.wdata, 32'd0);
`ifdef LSU_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 32'd0);
`endif
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed examples
    do_op(1, 0, SZ_B,  32'h103, 32'd0, 32'h8000_0000, 0);
    do_op(1, 0, SZ_HU, 32'h102, 32'd0, 32'h9ABC_0000, 3);
    do_op(0, 1, SZ_B,  32'h201, 32'h1234_56A5, 32'd0, 1);
    do_op(1, 0, SZ_W,  32'h102, 32'd0, 32'h5555_5555, 0);
    do_op(1, 1, SZ_W,  32'h040, 32'hCAFE_F00D, 32'h1111_1111, 1);
    do_op(1, 0, SZ_H,  32'h0FE, 32'd0, 32'h8001_7FFF, 2);
    do_op(0, 1, SZ_BU, 32'h010, 32'h0000_00FF, 32'd0, 0);
    do_op(1, 0, 3'b011, 32'h020, 32'd0, 32'd0, 0);
`ifdef LSU_TIMEOUT_EN
    do_op(1, 0, SZ_W, 32'h500, 32'd0, 32'h0BAD_0BAD, 1000);
    do_op(1, 0, SZ_W, 32'h504, 32'd0, 32'h7654_3210, TMO - 1);
`endif

    // Reset while a transaction is in flight
    exp_bus_q.push_back({1'b0, 32'h300, 4'b1111, 32'd0});
    ld_req    = 1'b1;
    size      = SZ_W;
    addr      = 32'h300;
    ack_delay = 1000;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_bus_req", 32'(bus.req), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(IDLE));
    check("async_rst_ld_data", ld_data, 32'd0);
    ld_req   = 1'b0;
    model_ld = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int k, dly;
      k  = $urandom_range(0, 2);
      sz = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
`ifdef LSU_TIMEOUT_EN
      dly = $urandom_range(0, TMO + 2);
`else
      dly = $urandom_range(0, 5);
`endif
      do_op(k != 1, k != 0, sz, a, $urandom, $urandom, dly);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    check("done_queue_drained", exp_done_q.size(), 32'd0);
    check("bus_queue_drained", exp_bus_q.size(), 32'd0);
    finish_report();
  end

endmodule
